// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
package wb_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned REG_ZERO   = 0;

  typedef enum logic {
    PRIO0,
    FORCE1
  } wb_state_e;

  typedef struct packed {
    logic                  valid;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/wb_starve_cnt.sv
// Saturating count of consecutive cycles src1 has waited; hit pulses on the
// increment that reaches LIMIT.
module wb_starve_cnt #(
  parameter int unsigned LIMIT = 4,
  parameter int unsigned CNT_W = $clog2(LIMIT + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  output logic hit
);

  logic [CNT_W-1:0] cnt;

  assign hit = inc & (cnt == CNT_W'(LIMIT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (!inc) begin
      cnt <= '0;
    end else if (cnt != CNT_W'(LIMIT)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Two-source register-file writeback arbiter: src0 priority, starvation-forced
// src1 grant, registered write port, x0 drop. `WB_BYPASS_EN adds write forwarding.
module regfile_wb_arbiter
  import wb_pkg::*;
#(
  parameter  int unsigned DATA_W       = DATA_W_DEF,
  parameter  int unsigned ADDR_W       = ADDR_W_DEF,
  parameter  int unsigned STARVE_LIMIT = 4,
  localparam int unsigned CNT_W        = $clog2(STARVE_LIMIT + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              src0_valid,
  output logic              src0_ready,
  input  logic [ADDR_W-1:0] src0_addr,
  input  logic [DATA_W-1:0] src0_data,
  input  logic              src1_valid,
  output logic              src1_ready,
  input  logic [ADDR_W-1:0] src1_addr,
  input  logic [DATA_W-1:0] src1_data,
  output logic              rg_wrt_en,
  output logic [ADDR_W-1:0] rg_wrt_addr,
  output logic [DATA_W-1:0] rg_wrt_data,
  output logic              starved,
  input  logic [ADDR_W-1:0] fwd_addr1,
  input  logic [ADDR_W-1:0] fwd_addr2,
  output logic              fwd_hit1,
  output logic              fwd_hit2,
  output logic [DATA_W-1:0] fwd_data
);

  wb_state_e         state;
  logic              src0_fire;
  logic              src1_fire;
  logic              win_fire;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_data;
  logic              cnt_hit;

  always_comb begin
    src0_ready = src0_valid & (state == PRIO0);
    src1_ready = src1_valid & ((state == FORCE1) | ~src0_valid);
  end

  assign src0_fire = src0_valid & src0_ready;
  assign src1_fire = src1_valid & src1_ready;
  assign win_fire  = src0_fire | src1_fire;
  assign win_addr  = src0_fire ? src0_addr : src1_addr;
  assign win_data  = src0_fire ? src0_data : src1_data;

  wb_starve_cnt #(
    .LIMIT (STARVE_LIMIT),
    .CNT_W (CNT_W)
  ) u_starve_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (src1_valid & ~src1_fire),
    .hit   (cnt_hit)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= PRIO0;
      starved <= 1'b0;
    end else begin
      case (state)
        PRIO0: begin
          if (cnt_hit) begin
            state   <= FORCE1;
            starved <= 1'b1;
          end
        end
        FORCE1: begin
          // Leaving on a dropped valid tolerates a src1 protocol violation.
          if (src1_fire | ~src1_valid) begin
            state   <= PRIO0;
            starved <= 1'b0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rg_wrt_en   <= 1'b0;
      rg_wrt_addr <= '0;
      rg_wrt_data <= '0;
    end else begin
      rg_wrt_en <= win_fire & (win_addr != ADDR_W'(REG_ZERO));
      if (win_fire) begin
        rg_wrt_addr <= win_addr;
        rg_wrt_data <= win_data;
      end
    end
  end

`ifdef WB_BYPASS_EN
  assign fwd_hit1 = rg_wrt_en & (rg_wrt_addr == fwd_addr1) & (fwd_addr1 != ADDR_W'(REG_ZERO));
  assign fwd_hit2 = rg_wrt_en & (rg_wrt_addr == fwd_addr2) & (fwd_addr2 != ADDR_W'(REG_ZERO));
  assign fwd_data = rg_wrt_data;
`else
  logic unused_fwd;
  assign unused_fwd = ^{fwd_addr1, fwd_addr2};
  assign fwd_hit1   = 1'b0;
  assign fwd_hit2   = 1'b0;
  assign fwd_data   = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: stimulus side checks handshakes
// against a wait-count model and queues expected writes; a monitor checks the write port.
module tb_regfile_wb_arbiter;

  localparam int unsigned LIMIT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        src0_valid, src0_ready, src1_valid, src1_ready;
  logic [4:0]  src0_addr, src1_addr, rg_wrt_addr, fwd_addr1, fwd_addr2;
  logic [31:0] src0_data, src1_data, rg_wrt_data, fwd_data;
  logic        rg_wrt_en, starved, fwd_hit1, fwd_hit2;

  regfile_wb_arbiter #(
    .DATA_W       (32),
    .ADDR_W       (5),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .src0_valid  (src0_valid),
    .src0_ready  (src0_ready),
    .src0_addr   (src0_addr),
    .src0_data   (src0_data),
    .src1_valid  (src1_valid),
    .src1_ready  (src1_ready),
    .src1_addr   (src1_addr),
    .src1_data   (src1_data),
    .rg_wrt_en   (rg_wrt_en),
    .rg_wrt_addr (rg_wrt_addr),
    .rg_wrt_data (rg_wrt_data),
    .starved     (starved),
    .fwd_addr1   (fwd_addr1),
    .fwd_addr2   (fwd_addr2),
    .fwd_hit1    (fwd_hit1),
    .fwd_hit2    (fwd_hit2),
    .fwd_data    (fwd_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          tag;
    logic        en;
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t q[$];
  int  n_total = 0;
  int  n_bad   = 0;
  int  cyc     = 0;
  bit  mon_on  = 0;
  int  waited  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: write issued on the edge after a fire, otherwise en=0 and addr/data hold.
  initial begin
    logic [4:0]  last_addr;
    logic [31:0] last_data;
    logic        e_en;
    logic        e_h1, e_h2;
    wr_t         ent;
    last_addr = '0;
    last_data = '0;
    forever begin
      @(negedge clk);
      if (mon_on) begin
        while (q.size() > 0 && q[0].tag < cyc - 1) begin
          chk("stale_write", 32'(q[0].tag), 32'(cyc - 1));
          void'(q.pop_front());
        end
        e_en = 1'b0;
        if (q.size() > 0 && q[0].tag == cyc - 1) begin
          ent       = q.pop_front();
          e_en      = ent.en;
          last_addr = ent.addr;
          last_data = ent.data;
        end
        chk("wr_en", 32'(rg_wrt_en), 32'(e_en));
        chk("wr_addr", 32'(rg_wrt_addr), 32'(last_addr));
        chk("wr_data", rg_wrt_data, last_data);
`ifdef WB_BYPASS_EN
        e_h1 = e_en && (fwd_addr1 == last_addr) && (fwd_addr1 != 0);
        e_h2 = e_en && (fwd_addr2 == last_addr) && (fwd_addr2 != 0);
        chk("fwd_data", fwd_data, last_data);
`else
        e_h1 = 1'b0;
        e_h2 = 1'b0;
        chk("fwd_data", fwd_data, 32'h0);
`endif
        chk("fwd_hit1", 32'(fwd_hit1), 32'(e_h1));
        chk("fwd_hit2", 32'(fwd_hit2), 32'(e_h2));
      end
    end
  end

  // One cycle: drive at posedge+1, sample/model at negedge, return to posedge+1.
  task automatic do_cycle(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                          input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                          input logic [4:0] f1, input logic [4:0] f2,
                          output logic r0, output logic r1, output logic st);
    bit  forced, e_r0, e_r1;
    wr_t ent;
    src0_valid = v0; src0_addr = a0; src0_data = d0;
    src1_valid = v1; src1_addr = a1; src1_data = d1;
    fwd_addr1  = f1; fwd_addr2 = f2;
    @(negedge clk);
    r0 = src0_ready; r1 = src1_ready; st = starved;
    forced = (waited >= int'(LIMIT));
    e_r0   = v0 && !forced;
    e_r1   = v1 && (forced || !v0);
    chk("src0_ready", 32'(r0), 32'(e_r0));
    chk("src1_ready", 32'(r1), 32'(e_r1));
    chk("starved", 32'(st), 32'(forced));
    if (e_r0 || e_r1) begin
      ent.tag  = cyc;
      ent.addr = e_r0 ? a0 : a1;
      ent.data = e_r0 ? d0 : d1;
      ent.en   = (ent.addr != 0);
      q.push_back(ent);
    end
    if (v1 && !e_r1) waited = (waited + 1 > int'(LIMIT)) ? int'(LIMIT) : waited + 1;
    else             waited = 0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic r0, r1, st;
    bit   pend;
    logic [4:0]  pa;
    logic [31:0] pd;
    reset = 1'b1;
    src0_valid = 0; src0_addr = 0; src0_data = 0;
    src1_valid = 0; src1_addr = 0; src1_data = 0;
    fwd_addr1 = 0; fwd_addr2 = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_en", 32'(rg_wrt_en), 32'h0);
    chk("rst_addr", 32'(rg_wrt_addr), 32'h0);
    chk("rst_data", rg_wrt_data, 32'h0);
    chk("rst_starved", 32'(starved), 32'h0);
    reset = 1'b0;

    // Reset arriving while a write is on the port.
    src0_valid = 1; src0_addr = 5; src0_data = 32'hDEADBEEF;
    @(posedge clk);
    #1;
    chk("mw_pre_en", 32'(rg_wrt_en), 32'h1);
    chk("mw_pre_data", rg_wrt_data, 32'hDEADBEEF);
    reset = 1'b1;
    #1;
    chk("mw_en", 32'(rg_wrt_en), 32'h0);
    chk("mw_addr", 32'(rg_wrt_addr), 32'h0);
    chk("mw_data", rg_wrt_data, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    src0_valid = 0;
    #1;
    chk("rel_en", 32'(rg_wrt_en), 32'h0);
    @(posedge clk);
    #1;
    chk("post_rel_en", 32'(rg_wrt_en), 32'h0);
    waited = 0;
    mon_on = 1;

    // src0 alone.
    do_cycle(1, 3, 32'h11, 0, 0, 0, 0, 0, r0, r1, st);
    chk("s0_alone_ready", 32'(r0), 32'h1);

    // Contention: src1 loses LIMIT cycles, then is forced.
    for (int k = 1; k <= int'(LIMIT); k++) begin
      do_cycle(1, 5'(k), 32'(k), 1, 7, 32'h22, 0, 0, r0, r1, st);
      chk("cont_lose_r1", 32'(r1), 32'h0);
    end
    do_cycle(1, 1, 32'h99, 1, 7, 32'h22, 0, 0, r0, r1, st);
    chk("cont_force_st", 32'(st), 32'h1);
    chk("cont_force_r0", 32'(r0), 32'h0);
    chk("cont_force_r1", 32'(r1), 32'h1);
    do_cycle(1, 2, 32'h33, 0, 0, 0, 0, 0, r0, r1, st);
    chk("cont_after_st", 32'(st), 32'h0);

    // x0 drop.
    do_cycle(0, 0, 0, 1, 0, 32'hFF, 0, 0, r0, r1, st);
    chk("x0_ready", 32'(r1), 32'h1);

    // src1 valid drop while forced.
    for (int k = 0; k < int'(LIMIT); k++)
      do_cycle(1, 4, 32'h40, 1, 6, 32'h66, 0, 0, r0, r1, st);
    do_cycle(1, 4, 32'h41, 0, 0, 0, 0, 0, r0, r1, st);
    chk("drop_st", 32'(st), 32'h1);
    chk("drop_r0", 32'(r0), 32'h0);
    do_cycle(1, 4, 32'h42, 0, 0, 0, 0, 0, r0, r1, st);
    chk("drop_r0_next", 32'(r0), 32'h1);
    chk("drop_st_next", 32'(st), 32'h0);

    // Pending write visible to the forwarding compare.
    do_cycle(1, 9, 32'h55, 0, 0, 0, 0, 0, r0, r1, st);
    do_cycle(0, 0, 0, 0, 0, 0, 9, 4, r0, r1, st);

    // Randomised traffic with src1 held until handshake (rare drops).
    pend = 0; pa = 0; pd = 0;
    for (int i = 0; i < 500; i++) begin
      if (!pend && $urandom_range(0, 99) < 45) begin
        pend = 1;
        pa   = 5'($urandom_range(0, 7));
        pd   = $urandom;
      end
      if (pend && $urandom_range(0, 99) < 3) pend = 0;
      do_cycle($urandom_range(0, 99) < 65, 5'($urandom_range(0, 7)), $urandom,
               pend, pa, pd,
               5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), r0, r1, st);
      if (r1) pend = 0;
    end

    do_cycle(0, 0, 0, 0, 0, 0, 0, 0, r0, r1, st);
    do_cycle(0, 0, 0, 0, 0, 0, 0, 0, r0, r1, st);
    chk("queue_drained", 32'(q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
